// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and command-error helper for alu_seq.
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SHR2 = 3'd4;
  localparam logic [2:0] OP_SHL1 = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  // Reserved opcodes (11x) and divide-by-zero are answered without touching the ALU.
  function automatic logic cmd_err(input logic [2:0] op, input logic b_zero);
    return (op == OP_DIV && b_zero) || op[2:1] == 2'b11;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW register file, two async read ports, one sync write port, sync clear.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NREG)-1:0] ra_addr_i,
  output logic [DW-1:0]           ra_data_o,
  input  logic [$clog2(NREG)-1:0] rb_addr_i,
  output logic [DW-1:0]           rb_data_o
);
  logic [DW-1:0] mem_q [NREG];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an 8-bit combinational ALU with register-file writeback.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_ld,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_ra,
  input  logic [$clog2(NREG)-1:0] cmd_rb,
  input  logic                    cmd_imm_en,
  input  logic [DW-1:0]           cmd_imm,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_err,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [2:0]              alu_op,
  output logic                    alu_en,
  input  logic [DW-1:0]           alu_f
);
  localparam int AW = $clog2(NREG);
  state_e        state_q, state_d;
  logic          rdy_q;
  logic [DW-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          err_q, err_d;
  logic [DW-1:0] ra_val, rb_val, b_sel, wdata;
  logic [AW-1:0] waddr;
  logic          acc, bad, we, cap;
  assign acc   = cmd_valid && rdy_q;
  assign cap   = state_q == CAPTURE;
  assign b_sel = cmd_imm_en ? cmd_imm : rb_val;
  assign bad   = !cmd_ld && cmd_err(cmd_op, b_sel == '0);
  // Loads write at accept; ALU results write at the end of CAPTURE.
  assign we    = (acc && cmd_ld) || cap;
  assign waddr = cap ? rd_q : cmd_rd;
  assign wdata = cap ? alu_f : cmd_imm;
  alu_regfile #(.NREG(NREG), .DW(DW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .ra_addr_i(cmd_ra),
    .ra_data_o(ra_val),
    .rb_addr_i(cmd_rb),
    .rb_data_o(rb_val)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == IDLE;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE    ? (acc ? ((cmd_ld || bad) ? RESP : ISSUE) : IDLE) :
              state_q == ISSUE   ? CAPTURE :
              state_q == CAPTURE ? RESP :
              (rsp_ready ? IDLE : RESP);
    a_d    = acc ? ra_val : a_q;
    b_d    = acc ? b_sel : b_q;
    op_d   = acc ? cmd_op : op_q;
    rd_d   = acc ? cmd_rd : rd_q;
    data_d = acc ? (cmd_ld ? cmd_imm : '0) : cap ? alu_f : data_q;
    err_d  = acc ? bad : cap ? 1'b0 : err_q;
  end
  always_comb begin
    cmd_ready = rdy_q;
    rsp_valid = state_q == RESP;
    rsp_data  = data_q;
    rsp_err   = err_q;
    alu_en    = state_q == ISSUE || cap;
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and randomized checks of alu_seq against a spec-level model.
module tb_alu_seq;
  import alu_seq_pkg::*;
  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic       ie;
    logic [7:0] imm;
    logic [7:0] ed;
    logic       ee;
  } cmd_t;
  logic       clk = 0, rst_n = 0;
  logic       cmd_valid = 0, cmd_ld = 0, cmd_imm_en = 0, rsp_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [1:0] cmd_rd = 0, cmd_ra = 0, cmd_rb = 0;
  logic [7:0] cmd_imm = 0;
  logic       cmd_ready, rsp_valid, rsp_err, alu_en;
  logic [7:0] rsp_data, alu_a, alu_b;
  logic [2:0] alu_op;
  wire  [7:0] alu_f;
  int n_cmp = 0, n_fail = 0, en_cnt = 0;
  int mregs [4];
  always #5 clk = ~clk;
  alu_seq #(.NREG(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_en(alu_en), .alu_f(alu_f)
  );
  // Stand-in for the team ALU: combinational, released to high-Z when not enabled.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[7:0];
      3'd3: return b == 0 ? 8'hFF : a / b;
      3'd4: return {2'b00, a[7:2]};
      3'd5: return {b[6:0], 1'b0};
      default: return 8'h00;
    endcase
  endfunction
  assign alu_f = alu_en ? alu_fn(alu_op, alu_a, alu_b) : 8'hzz;
  always @(negedge clk) if (alu_en === 1'b1) en_cnt++;
  function automatic cmd_t mk(input logic ld, input logic [2:0] op, input int rd, input int ra,
                              input int rb, input logic ie, input logic [7:0] imm,
                              input logic [7:0] ed, input logic ee);
    cmd_t c;
    c.ld = ld; c.op = op; c.rd = 2'(rd); c.ra = 2'(ra); c.rb = 2'(rb);
    c.ie = ie; c.imm = imm; c.ed = ed; c.ee = ee;
    return c;
  endfunction
  // Reference: integer arithmetic straight from the opcode table, then reduced mod 256.
  function automatic void ref_step(input cmd_t c, output logic [7:0] d, output logic e);
    int a, b, r;
    a = mregs[c.ra];
    b = c.ie ? int'(c.imm) : mregs[c.rb];
    e = 0;
    r = 0;
    if (c.ld) r = int'(c.imm);
    else if (c.op > 5 || (c.op == 3 && b == 0)) e = 1;
    else if (c.op == 0) r = a + b;
    else if (c.op == 1) r = a - b + 256;
    else if (c.op == 2) r = a * b;
    else if (c.op == 3) r = a / b;
    else if (c.op == 4) r = a / 4;
    else r = b * 2;
    r = r % 256;
    d = 8'(r);
    if (!e) mregs[c.rd] = r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic send(input cmd_t c, input int bp, output logic [7:0] d, output logic e,
                      output int lat, output int en);
    int t, en0;
    logic [7:0] d0;
    cmd_ld = c.ld; cmd_op = c.op; cmd_rd = c.rd; cmd_ra = c.ra; cmd_rb = c.rb;
    cmd_imm_en = c.ie; cmd_imm = c.imm; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    chk("accept", cmd_ready, 1);
    en0 = en_cnt;
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("rsp_seen", rsp_valid, 1);
    d0 = rsp_data;
    for (int k = 0; k < bp; k++) begin
      chk("bp_ready_low", cmd_ready, 0);
      chk("bp_data_stable", rsp_data, d0);
      @(negedge clk);
    end
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("ready_after_hs", cmd_ready, 1);
    en = en_cnt - en0;
  endtask
  cmd_t tab [17];
  initial begin
    logic [7:0] d, ed;
    logic e, ee;
    int lat, en;
    cmd_t c;
    tab[0]  = mk(1, 0,       0, 0, 0, 0, 200,   200,   0);
    tab[1]  = mk(1, 0,       1, 0, 0, 0, 100,   100,   0);
    tab[2]  = mk(0, OP_ADD,  2, 0, 1, 0, 0,     44,    0);
    tab[3]  = mk(1, 0,       0, 0, 0, 0, 13,    13,    0);
    tab[4]  = mk(0, OP_MUL,  3, 0, 0, 1, 20,    4,     0);
    tab[5]  = mk(0, OP_DIV,  1, 0, 0, 1, 4,     3,     0);
    tab[6]  = mk(1, 0,       2, 0, 0, 0, 8'hF3, 8'hF3, 0);
    tab[7]  = mk(0, OP_SHR2, 3, 2, 0, 0, 0,     8'h3C, 0);
    tab[8]  = mk(1, 0,       1, 0, 0, 0, 0,     0,     0);
    tab[9]  = mk(0, OP_DIV,  3, 0, 1, 0, 0,     0,     1);
    tab[10] = mk(0, OP_ADD,  0, 3, 0, 1, 0,     8'h3C, 0);
    tab[11] = mk(0, 3'd7,    0, 2, 0, 0, 0,     0,     1);
    tab[12] = mk(0, OP_SHL1, 1, 0, 0, 1, 8'h81, 8'h02, 0);
    tab[13] = mk(0, OP_SUB,  2, 1, 0, 0, 0,     198,   0);
    tab[14] = mk(0, OP_SUB,  2, 2, 0, 1, 10,    188,   0);
    tab[15] = mk(0, 3'd6,    3, 3, 3, 0, 0,     0,     1);
    tab[16] = mk(0, OP_ADD,  3, 3, 2, 0, 0,     248,   0);
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_a, alu_b, alu_op}, 0);
    rst_n = 1;
    chk("rst_release_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("rst_release_ready_high", cmd_ready, 1);
    foreach (tab[i]) begin
      ref_step(tab[i], ed, ee);
      send(tab[i], 0, d, e, lat, en);
      chk($sformatf("tab%0d_data", i), d, tab[i].ed);
      chk($sformatf("tab%0d_err", i), e, tab[i].ee);
      chk($sformatf("tab%0d_lat", i), lat, (tab[i].ld || tab[i].ee) ? 1 : 3);
      chk($sformatf("tab%0d_alu_en", i), en, (tab[i].ld || tab[i].ee) ? 0 : 2);
    end
    c = mk(0, OP_ADD, 1, 3, 0, 1, 7, 255, 0);
    ref_step(c, ed, ee);
    send(c, 5, d, e, lat, en);
    chk("bp_data", d, 255);
    chk("bp_err", e, 0);
    c = mk(0, OP_ADD, 2, 0, 0, 1, 5, 0, 0);
    cmd_ld = c.ld; cmd_op = c.op; cmd_rd = c.rd; cmd_ra = c.ra; cmd_rb = c.rb;
    cmd_imm_en = c.ie; cmd_imm = c.imm; cmd_valid = 1;
    chk("midop_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("midop_issue_en", alu_en, 1);
    @(negedge clk);
    chk("midop_capture_en", alu_en, 1);
    rst_n = 0;
    @(negedge clk);
    chk("midop_rst_outs", {rsp_valid, alu_en, cmd_ready}, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    @(negedge clk);
    chk("midop_idle_ready", cmd_ready, 1);
    chk("midop_no_rsp", rsp_valid, 0);
    c = mk(0, OP_ADD, 3, 2, 0, 1, 0, 0, 0);
    ref_step(c, ed, ee);
    send(c, 0, d, e, lat, en);
    chk("midop_rd_cleared", d, 0);
    for (int i = 0; i < 4; i++) begin
      c = mk(1, 0, i, 0, 0, 0, 8'($urandom), 0, 0);
      ref_step(c, ed, ee);
      send(c, 0, d, e, lat, en);
      chk("rnd_init", d, ed);
    end
    for (int i = 0; i < 150; i++) begin
      c = mk($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 5) == 0 ? 8'h00 : 8'($urandom), 0, 0);
      ref_step(c, ed, ee);
      send(c, $urandom_range(0, 3), d, e, lat, en);
      chk($sformatf("rnd%0d_data", i), d, ed);
      chk($sformatf("rnd%0d_err", i), e, ee);
      chk($sformatf("rnd%0d_lat", i), lat, (c.ld || ee) ? 1 : 3);
      chk($sformatf("rnd%0d_alu_en", i), en, (c.ld || ee) ? 0 : 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
